// File: rtl/mux3x1_pkg.sv
// Shared select encodings and types for the 3:1 routing mux.
package mux3x1_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_D0     = 2'b00;
   localparam sel_t SEL_D1     = 2'b01;
   localparam sel_t SEL_D2     = 2'b10;
   localparam sel_t SEL_D2_ALT = 2'b11;

endpackage : mux3x1_pkg

// File: rtl/mux2x1_cell.sv
// WIDTH-bit 2:1 mux cell; o_y = i_sel ? i_b : i_a.
module mux2x1_cell #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sel,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = i_a;
      if (i_sel) o_y = i_b;
   end

endmodule : mux2x1_cell

// File: rtl/mux3x1_design.sv
// 3:1 mux (s1 has priority) with combinational and registered outputs.
// Define MUX3X1_SELF_CHECK_EN to add a redundant AND-OR path and sticky err flag.
module mux3x1_design
   import mux3x1_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic             s0,
   input  logic             s1,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             err
);

   logic [WIDTH-1:0] w_inner;
   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] r_out_q;

   // Primary path: d0/d1 on s0, then that result or d2 on s1.
   mux2x1_cell #(.WIDTH(WIDTH)) u_mux_inner (
      .i_a   (d0),
      .i_b   (d1),
      .i_sel (s0),
      .o_y   (w_inner)
   );

   mux2x1_cell #(.WIDTH(WIDTH)) u_mux_outer (
      .i_a   (w_inner),
      .i_b   (d2),
      .i_sel (s1),
      .o_y   (w_out)
   );

   assign out = w_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out_q <= '0;
      else        r_out_q <= w_out;
   end

   assign out_q = r_out_q;

`ifdef MUX3X1_SELF_CHECK_EN
   sel_t             w_sel;
   logic [WIDTH-1:0] w_out_alt;
   logic             w_mismatch;
   logic             r_err;

   assign w_sel = {s1, s0};

   // Sum-of-products form kept structurally independent of the cell chain.
   assign w_out_alt = (d0 & {WIDTH{~w_sel[1] & ~w_sel[0]}})
                    | (d1 & {WIDTH{~w_sel[1] &  w_sel[0]}})
                    | (d2 & {WIDTH{ w_sel[1]}});

   assign w_mismatch = (w_out != w_out_alt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_err <= 1'b0;
      else if (w_mismatch) r_err <= 1'b1;
   end

   assign err = r_err;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && !r_err && w_mismatch)
         $display("mux3x1_design %m: primary/alternate disagree sel=%b out=%h alt=%h",
                  w_sel, w_out, w_out_alt);
   end
`endif
`else
   assign err = 1'b0;
`endif

endmodule : mux3x1_design

// File: tb/tb_mux3x1_design.sv
// Directed bench for mux3x1_design at WIDTH=1 and WIDTH=8.
module tb_mux3x1_design;

   logic       clk;
   logic       rst_n;

   logic       a_d0, a_d1, a_d2, a_s0, a_s1;
   logic       a_out, a_out_q, a_err;

   logic [7:0] b_d0, b_d1, b_d2;
   logic       b_s0, b_s1;
   logic [7:0] b_out, b_out_q;
   logic       b_err;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   mux3x1_design #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .d0    (a_d0),
      .d1    (a_d1),
      .d2    (a_d2),
      .s0    (a_s0),
      .s1    (a_s1),
      .out   (a_out),
      .out_q (a_out_q),
      .err   (a_err)
   );

   mux3x1_design #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .d0    (b_d0),
      .d1    (b_d1),
      .d2    (b_d2),
      .s0    (b_s0),
      .s1    (b_s1),
      .out   (b_out),
      .out_q (b_out_q),
      .err   (b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_mux(input logic [7:0] x0, input logic [7:0] x1,
                                          input logic [7:0] x2, input logic sel1,
                                          input logic sel0);
      case ({sel1, sel0})
         2'b00:   ref_mux = x0;
         2'b01:   ref_mux = x1;
         2'b10:   ref_mux = x2;
         default: ref_mux = x2;
      endcase
   endfunction

   logic [7:0] exp_a, exp_b;

   initial begin
      rst_n = 1'b0;
      {a_d0, a_d1, a_d2, a_s0, a_s1} = '0;
      b_d0 = 8'h00; b_d1 = 8'h00; b_d2 = 8'h00; b_s0 = 1'b0; b_s1 = 1'b0;

      // Reset state
      #3;
      check("rst_out_q1", {7'd0, a_out_q}, 8'h00);
      check("rst_out_q8", b_out_q, 8'h00);
      check("rst_err1", {7'd0, a_err}, 8'h00);
      check("rst_err8", {7'd0, b_err}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Hand-computed spot vectors, WIDTH=1
      a_d0 = 1'b1; a_d1 = 1'b0; a_d2 = 1'b0; a_s1 = 1'b0; a_s0 = 1'b0; #1;
      check("w1_vec00", {7'd0, a_out}, 8'h01);
      a_d0 = 1'b0; a_d1 = 1'b0; a_d2 = 1'b1; a_s1 = 1'b1; a_s0 = 1'b1; #1;
      check("w1_vec11", {7'd0, a_out}, 8'h01);

      // Exhaustive WIDTH=1 sweep
      for (int i = 0; i < 32; i++) begin
         logic [4:0] v;
         v = 5'(i);
         a_d0 = v[0]; a_d1 = v[1]; a_d2 = v[2]; a_s0 = v[3]; a_s1 = v[4];
         #1;
         exp_a = ref_mux({7'd0, v[0]}, {7'd0, v[1]}, {7'd0, v[2]}, v[4], v[3]);
         check($sformatf("w1_exh_%0d", i), {7'd0, a_out}, exp_a);
      end

      // Priority / don't-care, WIDTH=8
      b_d0 = 8'hA5; b_d1 = 8'h3C; b_d2 = 8'hF0;
      b_s1 = 1'b1; b_s0 = 1'b0; #1; check("w8_sel10", b_out, 8'hF0);
      b_s1 = 1'b1; b_s0 = 1'b1; #1; check("w8_sel11", b_out, 8'hF0);
      b_s1 = 1'b0; b_s0 = 1'b1; #1; check("w8_sel01", b_out, 8'h3C);
      b_s1 = 1'b0; b_s0 = 1'b0; #1; check("w8_sel00", b_out, 8'hA5);

      // Register latency
      @(posedge clk); #1;
      b_d0 = 8'h11; b_s1 = 1'b0; b_s0 = 1'b0;
      @(posedge clk); #1;
      check("lat_q_first", b_out_q, 8'h11);
      b_d1 = 8'h22; b_s0 = 1'b1; #1;
      check("lat_out_imm", b_out, 8'h22);
      check("lat_q_hold", b_out_q, 8'h11);
      @(posedge clk); #1;
      check("lat_q_next", b_out_q, 8'h22);

      // Asynchronous reset between edges
      #2;
      rst_n = 1'b0; #1;
      check("arst_q", b_out_q, 8'h00);
      check("arst_out", b_out, 8'h22);
      check("arst_err", {7'd0, b_err}, 8'h00);
      #1;
      rst_n = 1'b1; #1;
      check("arst_q_held", b_out_q, 8'h00);
      @(posedge clk); #1;
      check("arst_reload", b_out_q, 8'h22);

      // Random cycles: out vs model, out_q one cycle behind, err stays low
      for (int c = 0; c < 10; c++) begin
         a_d0 = 1'($urandom); a_d1 = 1'($urandom); a_d2 = 1'($urandom);
         a_s0 = 1'($urandom); a_s1 = 1'($urandom);
         b_d0 = 8'($urandom); b_d1 = 8'($urandom); b_d2 = 8'($urandom);
         b_s0 = 1'($urandom); b_s1 = 1'($urandom);
         #1;
         exp_a = ref_mux({7'd0, a_d0}, {7'd0, a_d1}, {7'd0, a_d2}, a_s1, a_s0);
         exp_b = ref_mux(b_d0, b_d1, b_d2, b_s1, b_s0);
         check($sformatf("rnd_out1_%0d", c), {7'd0, a_out}, exp_a);
         check($sformatf("rnd_out8_%0d", c), b_out, exp_b);
         @(posedge clk); #1;
         check($sformatf("rnd_q1_%0d", c), {7'd0, a_out_q}, exp_a);
         check($sformatf("rnd_q8_%0d", c), b_out_q, exp_b);
         check($sformatf("rnd_err1_%0d", c), {7'd0, a_err}, 8'h00);
         check($sformatf("rnd_err8_%0d", c), {7'd0, b_err}, 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mux3x1_design
